// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register addresses, Status/Cause bit positions, exception codes, FSM states.
package cp0_pkg;
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int STA_IE  = 0;
  localparam int STA_SYS = 1;
  localparam int STA_RI  = 2;
  localparam int STA_EXL = 3;
  localparam int CAU_IP  = 10;

  localparam logic [3:0] EXC_SYS = 4'b0100;
  localparam logic [3:0] EXC_RI  = 4'b1000;
  localparam logic [3:0] EXC_INT = 4'b0000;

  typedef enum logic {ST_RUN = 1'b0, ST_HANDLER = 1'b1} exc_state_e;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } mtc0_req_t;
endpackage

// File: rtl/cp0_regfile.sv
// Status/Cause/EPC/saved-Status storage, mtc0 writes, mfc0 read mux and the interrupt pending flag.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0000_0007
) (
  input  logic        clk,
  input  logic        rst_n,
  input  mtc0_req_t   wr,
  input  logic        entry,
  input  logic [3:0]  exc_code,
  input  logic [31:0] epc_val,
  input  logic        restore,
  input  logic        int_req,
  input  logic        int_entry,
  output logic [31:0] sta,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        pend,
  output logic [31:0] rdata
);
  logic [31:0] sta_q, saved_q, epc_q;
  logic [3:0]  code_q;
  logic        pend_q;
  logic        wr_sta, wr_cau, wr_epc;

  assign wr_sta = wr.we && wr.addr == CP0_STATUS;
  assign wr_cau = wr.we && wr.addr == CP0_CAUSE;
  assign wr_epc = wr.we && wr.addr == CP0_EPC;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sta_q   <= STATUS_RST;
      saved_q <= STATUS_RST;
      epc_q   <= '0;
      code_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      // Entry takes the whole register file for this cycle; any mtc0 is dropped.
      if (entry) begin
        sta_q   <= {sta_q[31:4], 1'b1, 3'b000};
        saved_q <= sta_q;
        epc_q   <= epc_val;
        code_q  <= exc_code;
      end else begin
        if (restore)     sta_q <= saved_q;
        else if (wr_sta) sta_q <= wr.wdata;
        if (wr_epc)      epc_q  <= wr.wdata;
        if (wr_cau)      code_q <= wr.wdata[5:2];
      end
      // Level request re-sets pend each cycle it is held, except on the entry that consumes it.
      if (int_entry)              pend_q <= 1'b0;
      else if (int_req)           pend_q <= 1'b1;
      else if (wr_cau && !entry)  pend_q <= wr.wdata[CAU_IP];
    end
  end

  assign sta   = sta_q;
  assign epc   = epc_q;
  assign pend  = pend_q;
  assign cause = {21'b0, pend_q, 4'b0, code_q, 2'b0};

  always_comb begin
    rdata = '0;
    case (wr.addr)
      CP0_STATUS: rdata = sta_q;
      CP0_CAUSE:  rdata = cause;
      CP0_EPC:    rdata = epc_q;
      default:    rdata = '0;
    endcase
  end
endmodule

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt control: RUN/HANDLER FSM, entry priority and registered PC redirect.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0800,
  parameter logic [31:0] STATUS_RST   = 32'h0000_0007
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inta,
  input  logic [3:0]  cause1,
  input  logic [31:0] pc_in,
  input  logic        eret,
  input  logic        int_req,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic [31:0] sta,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        redirect_vld,
  output logic [31:0] redirect_pc
);
  exc_state_e  state_q, state_d;
  mtc0_req_t   wr;
  logic        pend, take_exc, take_int, entry, ret;
  logic [31:0] ret_pc, epc_val;
  logic        rv_q;
  logic [31:0] rpc_q;

  assign wr = '{we: cp0_we, addr: cp0_addr, wdata: cp0_wdata};

  // During the redirect cycle the instruction in this stage is being flushed,
  // so it may not trigger entry or return; this also keeps redirects one cycle apart.
  always_comb begin
    state_d  = state_q;
    take_exc = 1'b0;
    take_int = 1'b0;
    ret      = 1'b0;
    case (state_q)
      ST_RUN: if (!rv_q) begin
        if (inta)                         take_exc = 1'b1;
        else if (pend && sta[STA_IE])     take_int = 1'b1;
        if (take_exc || take_int)         state_d  = ST_HANDLER;
      end
      ST_HANDLER: if (!rv_q && eret) begin
        ret     = 1'b1;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign entry   = take_exc | take_int;
  assign epc_val = take_exc ? pc_in + 32'd4 : pc_in;
  assign ret_pc  = (cp0_we && cp0_addr == CP0_EPC) ? cp0_wdata : epc;

  cp0_regfile #(.STATUS_RST(STATUS_RST)) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (wr),
    .entry     (entry),
    .exc_code  (take_exc ? cause1 : EXC_INT),
    .epc_val   (epc_val),
    .restore   (ret),
    .int_req   (int_req),
    .int_entry (take_int),
    .sta       (sta),
    .cause     (cause),
    .epc       (epc),
    .pend      (pend),
    .rdata     (cp0_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      rv_q    <= entry | ret;
      rpc_q   <= entry ? HANDLER_ADDR : (ret ? ret_pc : '0);
    end
  end

  assign redirect_vld = rv_q;
  assign redirect_pc  = rpc_q;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed vector table, hand-written corner sequences, randomized model check.
module tb_cp0_exc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, inta, eret, int_req, cp0_we;
  logic [3:0]  cause1;
  logic [31:0] pc_in, cp0_wdata;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_rdata, sta, cause, epc, redirect_pc;
  logic        redirect_vld;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inta(inta), .cause1(cause1), .pc_in(pc_in),
    .eret(eret), .int_req(int_req), .cp0_we(cp0_we), .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .sta(sta), .cause(cause),
    .epc(epc), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic        rst_n, inta, eret, irq, we;
    logic [3:0]  c1;
    logic [31:0] pc, wd;
    logic [4:0]  addr;
    logic [31:0] e_sta, e_cause, e_epc, e_rpc;
    logic        e_rv;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int rst, input int ia, input int c1, input int pc, input int er,
                     input int irq, input int we, input int addr, input int wd,
                     input int s, input int c, input int e, input int rv, input int rpc);
    vec_t v;
    v.rst_n = rst[0]; v.inta = ia[0]; v.c1 = c1[3:0]; v.pc = pc; v.eret = er[0];
    v.irq = irq[0]; v.we = we[0]; v.addr = addr[4:0]; v.wd = wd;
    v.e_sta = s; v.e_cause = c; v.e_epc = e; v.e_rv = rv[0]; v.e_rpc = rpc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic ia, input logic [3:0] c1, input logic [31:0] pc,
                       input logic er, input logic irq, input logic we, input logic [4:0] a,
                       input logic [31:0] wd);
    rst_n = r; inta = ia; cause1 = c1; pc_in = pc; eret = er; int_req = irq;
    cp0_we = we; cp0_addr = a; cp0_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  // Reference model: architectural state plus "in handler" and "redirect issued last cycle".
  logic [31:0] m_sta, m_saved, m_epc, m_rpc;
  logic [3:0]  m_code;
  logic        m_pend, m_inh, m_rv;

  function automatic logic [31:0] m_cause();
    return (32'(m_pend) << 10) | (32'(m_code) << 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd12) return m_sta;
    if (a == 5'd13) return m_cause();
    if (a == 5'd14) return m_epc;
    return 32'h0;
  endfunction

  task automatic m_step();
    logic exc, irq_t, ret, wsta, wcau, wepc;
    logic [31:0] n_sta, n_saved, n_epc, n_rpc;
    logic [3:0]  n_code;
    logic        n_pend, n_inh, n_rv;
    if (!rst_n) begin
      m_sta = 32'h7; m_saved = 32'h7; m_epc = 0; m_code = 0; m_pend = 0;
      m_inh = 0; m_rv = 0; m_rpc = 0;
      return;
    end
    exc   = !m_inh && !m_rv && inta;
    irq_t = !m_inh && !m_rv && !inta && m_pend && m_sta[0];
    ret   = m_inh && !m_rv && eret;
    wsta  = cp0_we && cp0_addr == 5'd12;
    wcau  = cp0_we && cp0_addr == 5'd13;
    wepc  = cp0_we && cp0_addr == 5'd14;
    n_sta = m_sta; n_saved = m_saved; n_epc = m_epc; n_code = m_code; n_pend = m_pend;
    n_inh = m_inh; n_rv = 0; n_rpc = 0;
    if (exc || irq_t) begin
      n_saved = m_sta;
      n_sta   = (m_sta & ~32'hF) | 32'h8;
      n_epc   = exc ? pc_in + 32'd4 : pc_in;
      n_code  = exc ? cause1 : 4'h0;
      n_inh   = 1; n_rv = 1; n_rpc = 32'h800;
    end else begin
      if (wepc) n_epc = cp0_wdata;
      if (wcau) n_code = cp0_wdata[5:2];
      if (ret) begin
        n_sta = m_saved; n_inh = 0; n_rv = 1; n_rpc = n_epc;
      end else if (wsta) n_sta = cp0_wdata;
    end
    if (irq_t) n_pend = 0;
    else if (int_req) n_pend = 1;
    else if (wcau && !exc) n_pend = cp0_wdata[10];
    m_sta = n_sta; m_saved = n_saved; m_epc = n_epc; m_code = n_code; m_pend = n_pend;
    m_inh = n_inh; m_rv = n_rv; m_rpc = n_rpc;
  endtask

  initial begin
    // rst ia c1 pc er irq we addr wd | sta cause epc rv rpc
    add(0,0,0,0,0,0,0,0,0,                       32'h7, 0, 0, 0, 0);
    add(0,0,0,0,0,0,0,0,0,                       32'h7, 0, 0, 0, 0);
    add(1,1,4,32'h100,0,0,0,0,0,                 32'h8, 32'h10, 32'h104, 1, 32'h800);
    add(1,0,0,0,0,0,0,0,0,                       32'h8, 32'h10, 32'h104, 0, 0);
    add(1,0,0,0,1,0,0,0,0,                       32'h7, 32'h10, 32'h104, 1, 32'h104);
    add(1,0,0,0,0,0,0,0,0,                       32'h7, 32'h10, 32'h104, 0, 0);
    add(1,1,8,32'h200,0,1,0,0,0,                 32'h8, 32'h420, 32'h204, 1, 32'h800);
    add(1,0,0,0,0,0,0,0,0,                       32'h8, 32'h420, 32'h204, 0, 0);
    add(1,0,0,0,1,0,0,0,0,                       32'h7, 32'h420, 32'h204, 1, 32'h204);
    add(1,0,0,32'h300,0,0,0,0,0,                 32'h7, 32'h420, 32'h204, 0, 0);
    add(1,0,0,32'h340,0,0,0,0,0,                 32'h8, 32'h0, 32'h340, 1, 32'h800);
    add(1,0,0,0,0,0,0,0,0,                       32'h8, 32'h0, 32'h340, 0, 0);
    add(1,0,0,0,1,0,1,14,32'h300,                32'h7, 32'h0, 32'h300, 1, 32'h300);
    add(1,0,0,0,0,0,1,12,0,                      32'h0, 32'h0, 32'h300, 0, 0);
    add(1,0,0,0,0,1,0,0,0,                       32'h0, 32'h400, 32'h300, 0, 0);
    add(1,0,0,0,0,0,0,0,0,                       32'h0, 32'h400, 32'h300, 0, 0);
    add(1,0,0,0,0,0,1,12,1,                      32'h1, 32'h400, 32'h300, 0, 0);
    add(1,0,0,32'h500,0,0,0,0,0,                 32'h8, 32'h0, 32'h500, 1, 32'h800);
    add(1,0,0,0,0,0,0,0,0,                       32'h8, 32'h0, 32'h500, 0, 0);
    add(1,0,0,0,1,0,0,0,0,                       32'h1, 32'h0, 32'h500, 1, 32'h500);
    add(1,0,0,0,0,0,0,0,0,                       32'h1, 32'h0, 32'h500, 0, 0);
    add(1,1,4,32'hFFFF_FFFC,0,0,1,14,32'hDEAD,   32'h8, 32'h10, 32'h0, 1, 32'h800);
    add(1,0,0,0,0,0,0,0,0,                       32'h8, 32'h10, 32'h0, 0, 0);
    add(1,0,0,0,1,0,1,12,32'hF0,                 32'h1, 32'h10, 32'h0, 1, 32'h0);
    add(1,0,0,0,0,0,0,0,0,                       32'h1, 32'h10, 32'h0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].inta, vecs[i].c1, vecs[i].pc, vecs[i].eret,
            vecs[i].irq, vecs[i].we, vecs[i].addr, vecs[i].wd);
      @(posedge clk); #1;
      chk($sformatf("vec%0d sta", i),   sta,   vecs[i].e_sta);
      chk($sformatf("vec%0d cause", i), cause, vecs[i].e_cause);
      chk($sformatf("vec%0d epc", i),   epc,   vecs[i].e_epc);
      chk($sformatf("vec%0d rv", i),    32'(redirect_vld), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("vec%0d rpc", i), redirect_pc, vecs[i].e_rpc);
    end

    // mfc0 reads, and no forwarding of a same-cycle mtc0
    idle(); cp0_addr = 5'd12; #1 chk("rd sta", cp0_rdata, 32'h1);
    cp0_addr = 5'd13; #1 chk("rd cause", cp0_rdata, 32'h10);
    cp0_addr = 5'd14; #1 chk("rd epc", cp0_rdata, 32'h0);
    cp0_addr = 5'd5;  #1 chk("rd other", cp0_rdata, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h55);
    #1 chk("rd pre-edge", cp0_rdata, 32'h1);
    @(posedge clk); #1;
    chk("rd post-edge", cp0_rdata, 32'h55);

    // reset the cycle after entry kills the pending redirect
    drive(1'b1, 1'b1, 4'h8, 32'h40, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    chk("rst entry rv", 32'(redirect_vld), 32'h1);
    chk("rst entry sta", sta, 32'h58);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    chk("rst rv", 32'(redirect_vld), 32'h0);
    chk("rst sta", sta, 32'h7);
    chk("rst epc", epc, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    chk("run eret ignored", 32'(redirect_vld), 32'h0);
    chk("run eret sta", sta, 32'h7);

    // randomized against the model
    idle(); rst_n = 1'b0; m_step();
    @(posedge clk); #1;
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 2));
      drive(($urandom_range(0, 60) != 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 1) != 0) ? 4'b0100 : 4'b1000,
            ($urandom_range(0, 20) == 0) ? 32'hFFFF_FFFC : ($urandom & ~32'h3),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 3) == 0), a, $urandom);
      #1 chk("rnd rdata", cp0_rdata, m_read(cp0_addr));
      m_step();
      @(posedge clk); #1;
      chk("rnd sta", sta, m_sta);
      chk("rnd cause", cause, m_cause());
      chk("rnd epc", epc, m_epc);
      chk("rnd rv", 32'(redirect_vld), 32'(m_rv));
      if (m_rv) chk("rnd rpc", redirect_pc, m_rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
